rand_word_packer: RTL and testbench
===================================

// Module: rand_word_packer
// PURPOSE
//  Packs the 4-bit pseudo-random nibble stream from the on-chip LFSR into WORD_W-bit words.
//  Completed words are buffered in a small FIFO and offered downstream on a valid/ready port.
//  Sits directly after the LFSR. Consumers are the random-stimulus and display paths.
// PARAMETERS
//  WORD_W      16  output word width; multiple of 4, >= 8
//  FIFO_DEPTH  4   words buffered; power of 2, >= 2
// PORTS
//  clk_i        in   1                       single clock, all logic on posedge
//  rst_i        in   1                       synchronous, active-high reset
//  enable_i     in   1                       consume rnd_i this cycle
//  rnd_i        in   4                       LFSR nibble, valid every cycle
//  word_o       out  WORD_W                  FIFO head word
//  valid_o      out  1                       FIFO non-empty
//  ready_i      in   1                       downstream accepts word_o when valid_o&&ready_i
//  level_o      out  $clog2(FIFO_DEPTH)+1    words currently buffered
//  drop_cnt_o   out  8                       dropped-word count (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (rst_i=1 at posedge) sets: sreg=0, nib_cnt=0, FIFO empty, valid_o=0, word_o=0, level_o=0, drop_cnt_o=0.
//  - word_o reads 0 whenever the FIFO is empty. Reset mid-stream discards the partial word and all buffered words.
//  - Shift: an enabled, non-stalled cycle does sreg <= {sreg[WORD_W-5:0], rnd_i} and nib_cnt++.
//    The first nibble ends up in the MSBs of the word.
//  - Completion: when nib_cnt==NIB-1 (NIB=WORD_W/4) and the nibble is consumed:
//    - push {sreg[WORD_W-5:0], rnd_i} to the FIFO;
//    - nib_cnt wraps to 0.
//  - Latency: last nibble consumed at edge t gives valid_o=1 with that word at t+1 (if FIFO was empty).
//  - Pop: valid_o && ready_i at an edge advances rd_ptr. ready_i with valid_o=0 is ignored.
//  - Full: push is allowed when full iff a pop happens in the same cycle; level_o is then unchanged.
//  - Simultaneous push+pop when empty is not possible (nothing to pop). The push lands and level_o becomes 1.
//  - Stall (default build): nib_cnt==NIB-1 && full && !pop means no shift and no count advance; rnd_i is ignored that cycle.
//  - enable_i=0: the packer holds state; the FIFO still pops.
//  - Pointers are $clog2(FIFO_DEPTH)+1 bits wide and wrap naturally. full = MSBs differ && LSBs equal.
//  - FSM (2 states):
//    - FILL: nib_cnt<NIB-1.
//    - LAST: nib_cnt==NIB-1; exits to FILL on push, or stays in LAST on stall.
// CONFIGURATION
//  RAND_PACKER_DROP_EN undefined:
//    - full without pop stalls as above;
//    - drop_cnt_o tied to 0.
//  RAND_PACKER_DROP_EN defined:
//    - never stalls; the completed word is discarded when full without pop, and nib_cnt still wraps;
//    - drop_cnt_o increments per discarded word, saturating at 8'hFF, and is cleared by rst_i.
// STRUCTURE
//  - Package rand_pkg holds:
//    - localparam NIBBLE_W=4;
//    - typedef enum logic {PK_FILL, PK_LAST} pk_state_e;
//    - function nib_per_word(w) = w/NIBBLE_W.
//  - Sub-module rand_sync_fifo #(W,DEPTH) holds the storage, pointers, full/empty and level logic.
//  - The top holds sreg, nib_cnt, the FSM and the drop counter.
// TESTING (WORD_W=16, FIFO_DEPTH=4)
//  1. Reset, enable_i=1, ready_i=1, rnd_i = F,9,5,A on 4 edges
//     -> word_o=16'hF95A with valid_o=1 one cycle after the 4th edge; level_o=1, then 0 after pop.
//  2. ready_i=0, enable_i=1 for 20 cycles of rnd_i=4'h3
//     -> level_o=4 after 16 nibbles; default build: stalls with level_o=4, no pops;
//        DROP_EN build: drop_cnt_o=1 after 20 cycles.
//  3. Full FIFO, ready_i=1 on the cycle the 4th word completes
//     -> push and pop together, level_o stays 4, no stall/drop, FIFO order preserved.
//  4. enable_i toggled 1/0 every cycle with rnd_i = 1,2,3,4 on enabled cycles
//     -> single word 16'h1234 after 4 enabled cycles; disabled cycles leave sreg unchanged.
//  5. Assert rst_i after 2 nibbles with 2 words buffered
//     -> next cycle valid_o=0, level_o=0, word_o=0; next 4 nibbles A,B,C,D give 16'hABCD.
//  6. DROP_EN: hold ready_i=0 through 300 further words after full
//     -> drop_cnt_o saturates at 8'hFF and stays there.

Source files
------------

// File: rtl/rand_pkg.sv
// Shared types and helpers for the random word packer.
// Holds the nibble width, the packer FSM state type and nibble-count helper.
package rand_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic {
        PK_FILL,
        PK_LAST
    } pk_state_e;

    function automatic int nib_per_word(input int w);
        return w / NIBBLE_W;
    endfunction

endpackage

// File: rtl/rand_sync_fifo.sv
// Synchronous FIFO of W-bit words with extended-pointer full/empty detection.
// Ports: clk_i, rst_i (sync, active-high), push_i/data_i write side,
//        ready_i pop request, data_o head (0 when empty), valid_o non-empty,
//        full_o, level_o word count.
module rand_sync_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [W-1:0]               data_i,
    input  logic                       ready_i,
    output logic [W-1:0]               data_o,
    output logic                       valid_o,
    output logic                       full_o,
    output logic [$clog2(DEPTH):0]     level_o
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             empty;
    logic             do_pop;
    logic             do_push;

    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full_o = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = ready_i && !empty;
    // When full, a write only lands if the head leaves on the same edge.
    assign do_push = push_i && (!full_o || do_pop);

    assign valid_o = !empty;
    assign data_o  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    assign level_o = wr_ptr_q - rd_ptr_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = data_i;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/rand_word_packer.sv
// Packs the 4-bit LFSR nibble stream into WORD_W-bit words, first nibble in
// the MSBs, and buffers finished words in a FIFO with a valid/ready output.
// Ports: clk_i, rst_i (sync, active-high), enable_i, rnd_i nibble in,
//        word_o/valid_o/ready_i output handshake, level_o FIFO occupancy,
//        drop_cnt_o count of discarded words.
// Build option RAND_PACKER_DROP_EN: discard completed words on a full FIFO
// instead of stalling, and count them in drop_cnt_o (saturating at 8'hFF).
module rand_word_packer
    import rand_pkg::*;
#(
    parameter int WORD_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          enable_i,
    input  logic [3:0]                    rnd_i,
    output logic [WORD_W-1:0]             word_o,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic [$clog2(FIFO_DEPTH):0]   level_o,
    output logic [7:0]                    drop_cnt_o
);

    localparam int NIB   = nib_per_word(WORD_W);
    localparam int CNT_W = $clog2(NIB);
    localparam int SR_W  = WORD_W - NIBBLE_W;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIB - 1);
    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(NIB - 2);

    // Only the nibbles gathered so far need storing; the final nibble goes
    // straight from rnd_i into the pushed word.
    logic [SR_W-1:0]   sreg_q, sreg_d;
    logic [CNT_W-1:0]  nib_cnt_q, nib_cnt_d;
    pk_state_e         state_q, state_d;

    logic              fifo_full;
    logic              pop;
    logic              complete;
    logic              push;
    logic              stall;
    logic              shift;
    logic [WORD_W-1:0] push_word;

    assign pop       = valid_o && ready_i;
    assign complete  = enable_i && (state_q == PK_LAST);
    assign push      = complete && (!fifo_full || pop);
    assign push_word = {sreg_q, rnd_i};

`ifdef RAND_PACKER_DROP_EN
    logic       drop;
    logic [7:0] drop_cnt_q, drop_cnt_d;

    assign stall = 1'b0;
    assign drop  = complete && fifo_full && !pop;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt_o = drop_cnt_q;
`else
    assign stall      = complete && fifo_full && !pop;
    assign drop_cnt_o = '0;
`endif

    assign shift = enable_i && !stall;

    always_comb begin
        sreg_d    = sreg_q;
        nib_cnt_d = nib_cnt_q;
        state_d   = state_q;
        if (shift) begin
            sreg_d = {sreg_q[SR_W-NIBBLE_W-1:0], rnd_i};
            unique case (state_q)
                PK_FILL: begin
                    nib_cnt_d = nib_cnt_q + 1'b1;
                    if (nib_cnt_q == PRE_LAST) begin
                        state_d = PK_LAST;
                    end
                end
                PK_LAST: begin
                    nib_cnt_d = '0;
                    state_d   = PK_FILL;
                end
                default: begin
                    nib_cnt_d = '0;
                    state_d   = PK_FILL;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sreg_q    <= '0;
            nib_cnt_q <= '0;
            state_q   <= PK_FILL;
        end else begin
            sreg_q    <= sreg_d;
            nib_cnt_q <= nib_cnt_d;
            state_q   <= state_d;
        end
    end

    // nib_cnt mirrors the FSM; LAST is exactly nib_cnt == NIB-1.
    logic unused_cnt;
    assign unused_cnt = ^{nib_cnt_q == LAST_CNT};

    rand_sync_fifo #(
        .W     (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .data_i  (push_word),
        .ready_i (ready_i),
        .data_o  (word_o),
        .valid_o (valid_o),
        .full_o  (fifo_full),
        .level_o (level_o)
    );

endmodule

// File: tb/tb_rand_word_packer.sv
// Self-checking bench for rand_word_packer (WORD_W=16, FIFO_DEPTH=4).
// Directed scenarios plus random traffic against a queue-based reference model.
module tb_rand_word_packer;

    localparam int WORD_W = 16;
    localparam int DEPTH  = 4;
    localparam int NIB    = WORD_W / 4;

    logic              clk_i;
    logic              rst_i;
    logic              enable_i;
    logic [3:0]        rnd_i;
    logic [WORD_W-1:0] word_o;
    logic              valid_o;
    logic              ready_i;
    logic [2:0]        level_o;
    logic [7:0]        drop_cnt_o;

    rand_word_packer #(
        .WORD_W     (WORD_W),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .enable_i   (enable_i),
        .rnd_i      (rnd_i),
        .word_o     (word_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .level_o    (level_o),
        .drop_cnt_o (drop_cnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Reference model: nibbles collected so far, words expected out in order,
    // number of words buffered and number of words discarded.
    logic [3:0]        part[$];
    logic [WORD_W-1:0] exp_q[$];
    int                m_level = 0;
    int                m_drop  = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: a transfer happens at the coming edge when
    // valid_o && ready_i are both high mid-cycle.
    always @(negedge clk_i) begin
        if (!rst_i && valid_o && ready_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected got %h want none", word_o);
            end else begin
                chk("sb_word", 32'(word_o), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic model_step(input logic en, input logic [3:0] rnd,
                              input logic rdy);
        logic              do_pop;
        logic [WORD_W-1:0] w;
        do_pop = (m_level > 0) && rdy;
        if (en) begin
            if (part.size() == NIB - 1) begin
                if (m_level < DEPTH || do_pop) begin
                    w = '0;
                    foreach (part[i]) w = (w << 4) | WORD_W'(part[i]);
                    w = (w << 4) | WORD_W'(rnd);
                    exp_q.push_back(w);
                    m_level++;
                    part.delete();
                end else begin
`ifdef RAND_PACKER_DROP_EN
                    part.delete();
                    if (m_drop < 255) m_drop++;
`endif
                end
            end else begin
                part.push_back(rnd);
            end
        end
        if (do_pop) m_level--;
    endtask

    task automatic check_state();
        chk("level", 32'(level_o), 32'(m_level));
        chk("valid", 32'(valid_o), 32'(m_level > 0));
        chk("drop", 32'(drop_cnt_o), 32'(m_drop));
        if (m_level == 0) chk("word_empty", 32'(word_o), 32'h0);
    endtask

    task automatic cycle(input logic en, input logic [3:0] rnd,
                         input logic rdy);
        enable_i = en;
        rnd_i    = rnd;
        ready_i  = rdy;
        model_step(en, rnd, rdy);
        @(posedge clk_i);
        #1;
        check_state();
    endtask

    task automatic do_reset();
        rst_i    = 1'b1;
        enable_i = 1'b1;
        rnd_i    = 4'h7;
        ready_i  = 1'b0;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        part.delete();
        exp_q.delete();
        m_level = 0;
        m_drop  = 0;
        chk("rst_valid", 32'(valid_o), 32'h0);
        chk("rst_level", 32'(level_o), 32'h0);
        chk("rst_word", 32'(word_o), 32'h0);
        chk("rst_drop", 32'(drop_cnt_o), 32'h0);
    endtask

    initial begin
        logic [3:0] t1 [4];
        logic [3:0] t5 [4];
        t1 = '{4'hF, 4'h9, 4'h5, 4'hA};
        t5 = '{4'hA, 4'hB, 4'hC, 4'hD};
        rst_i    = 1'b1;
        enable_i = 1'b0;
        rnd_i    = 4'h0;
        ready_i  = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;

        // 1: one word, first nibble in MSBs, one-cycle latency.
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1'b1, t1[i], 1'b1);
        chk("t1_word", 32'(word_o), 32'h0000F95A);
        chk("t1_valid", 32'(valid_o), 32'h1);
        cycle(1'b0, 4'h0, 1'b1);
        chk("t1_level_after", 32'(level_o), 32'h0);

        // 2: fill the FIFO with ready low.
        for (int i = 0; i < 16; i++) cycle(1'b1, 4'h3, 1'b0);
        chk("t2_full", 32'(level_o), 32'h4);
        for (int i = 0; i < 4; i++) cycle(1'b1, 4'h3, 1'b0);
        chk("t2_hold", 32'(level_o), 32'h4);
`ifdef RAND_PACKER_DROP_EN
        chk("t2_drop", 32'(drop_cnt_o), 32'h1);
`endif

        // 3: completion on a full FIFO with a simultaneous pop.
        for (int i = 0; i < NIB && part.size() != NIB - 1; i++)
            cycle(1'b1, 4'h6, 1'b0);
        cycle(1'b1, 4'h9, 1'b1);
        chk("t3_level", 32'(level_o), 32'h4);
        for (int i = 0; i < 6; i++) cycle(1'b0, 4'h0, 1'b1);
        chk("t3_drained", 32'(level_o), 32'h0);

        // 4: enable toggling; disabled cycles carry junk nibbles.
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            cycle(1'b0, 4'($urandom), 1'b0);
            cycle(1'b1, 4'(i), 1'b0);
        end
        chk("t4_word", 32'(word_o), 32'h00001234);
        cycle(1'b0, 4'h0, 1'b1);

        // 5: reset mid-stream with buffered words and a partial word.
        for (int i = 0; i < 2 * NIB + 2; i++) cycle(1'b1, 4'($urandom), 1'b0);
        chk("t5_level_pre", 32'(level_o), 32'h2);
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1'b1, t5[i], 1'b0);
        chk("t5_word", 32'(word_o), 32'h0000ABCD);
        cycle(1'b0, 4'h0, 1'b1);

`ifdef RAND_PACKER_DROP_EN
        // 6: drop counter saturation.
        for (int i = 0; i < (DEPTH + 300) * NIB; i++)
            cycle(1'b1, 4'($urandom), 1'b0);
        chk("t6_sat", 32'(drop_cnt_o), 32'h000000FF);
        for (int i = 0; i < 8; i++) cycle(1'b1, 4'($urandom), 1'b0);
        chk("t6_stay", 32'(drop_cnt_o), 32'h000000FF);
`endif

        // Random traffic with varying ready pressure.
        do_reset();
        for (int seg = 0; seg < 12; seg++) begin
            int rdy_pct;
            rdy_pct = (seg % 3 == 0) ? 10 : (seg % 3 == 1) ? 50 : 90;
            for (int i = 0; i < 120; i++) begin
                cycle(($urandom_range(0, 99) < 80),
                      4'($urandom),
                      ($urandom_range(0, 99) < rdy_pct));
            end
        end
        chk("sb_left", 32'(exp_q.size()), 32'(level_o));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
